rca_pr_controller: RTL and testbench

- Consumer end of the partial-reconfiguration (PR) request queue fed by the PR queue writeback unit.
- Pops one request at a time. Each request is (rca_id, cfg_id). For each request the block:
  - waits for the target RCA slot to drain,
  - issues a trigger to the external PR controller (PRC),
  - waits for done or error,
  - updates the per-slot loaded-configuration table,
  - emits a one-cycle status pulse.
- Drives per-slot reconfiguring flags so decode/issue stalls RCA instructions targeting a slot under reconfiguration.

---
 rtl/rca_pr_controller_pkg.sv | 31 +++
 rtl/rca_pr_controller_cfg_table.sv | 33 +++
 rtl/rca_pr_controller.sv | 166 ++++++++++++++++
 tb/tb_rca_pr_controller.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pr_controller_pkg.sv
// Shared sizing, request/state types and a slot-mask helper for the PR request consumer.
package rca_pr_controller_pkg;

   localparam int NUM_RCAS = 3;
   localparam int RCA_ID_W = 2;
   localparam int CFG_ID_W = 4;
   localparam logic [CFG_ID_W-1:0] INVALID_CFG = '1;

   typedef struct packed {
      logic [RCA_ID_W-1:0] rca_id;
      logic [CFG_ID_W-1:0] cfg_id;
   } pr_request_t;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DRAIN,
      TRIGGER,
      WAIT_DONE,
      REPORT
   } pr_state_t;

   // One-hot slot mask; an out-of-range id yields an all-zero mask.
   function automatic logic [NUM_RCAS-1:0] slot_onehot(input logic [RCA_ID_W-1:0] id);
      logic [NUM_RCAS-1:0] mask;
      for (int i = 0; i < NUM_RCAS; i++) begin
         mask[i] = (id == RCA_ID_W'(i));
      end
      return mask;
   endfunction

endpackage

// File: rtl/rca_pr_controller_cfg_table.sv
// Per-slot loaded-configuration register file: one write port, all entries readable at once.
module rca_pr_controller_cfg_table
   import rca_pr_controller_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [RCA_ID_W-1:0]          wr_idx,
   input  logic [CFG_ID_W-1:0]          wr_data,
   output logic [NUM_RCAS*CFG_ID_W-1:0] rd_all
);

   logic [CFG_ID_W-1:0] entries [NUM_RCAS];

   // Entry storage; a write to an out-of-range index matches no entry and is dropped.
   // NOTE: this small table is reset on purpose -- INVALID_CFG after reset is architecturally visible, unlike a data RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_RCAS; i++) entries[i] <= INVALID_CFG;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_RCAS; i++) begin
            if (wr_idx == RCA_ID_W'(i)) entries[i] <= wr_data;
         end
      end
   end

   // Flatten entries so slot i sits at bits [i*CFG_ID_W +: CFG_ID_W].
   always_comb begin
      rd_all = '0;
      for (int i = 0; i < NUM_RCAS; i++) rd_all[i*CFG_ID_W +: CFG_ID_W] = entries[i];
   end

endmodule

// File: rtl/rca_pr_controller.sv
// Pops PR requests, drains the target slot, triggers the PRC, tracks loaded configs, reports status.
module rca_pr_controller
   import rca_pr_controller_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [RCA_ID_W-1:0]          req_rca_id,
   input  logic [CFG_ID_W-1:0]          req_cfg_id,
   input  logic [NUM_RCAS-1:0]          rca_idle,
   output logic                         prc_valid,
   input  logic                         prc_ready,
   output logic [RCA_ID_W-1:0]          prc_rca_id,
   output logic [CFG_ID_W-1:0]          prc_cfg_id,
   input  logic                         prc_done,
   input  logic                         prc_error,
   output logic [NUM_RCAS-1:0]          rca_reconfiguring,
   output logic [NUM_RCAS*CFG_ID_W-1:0] cur_cfg_id,
   output logic                         status_valid,
   output logic [RCA_ID_W-1:0]          status_rca_id,
   output logic                         status_error
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   pr_state_t           state, state_nxt;
   pr_request_t         hold_q;
   logic                err_q;
   logic [CNT_W-1:0]    cnt_q;

   logic                pop, pop_err, pop_stall;
   logic                err_load, err_val, cnt_clr;
   logic                tbl_we;
   logic [CFG_ID_W-1:0] tbl_wdata;
   logic                req_in_range, loaded_match, drain_ok;

   assign req_in_range = (32'(req_rca_id) < NUM_RCAS);
   assign drain_ok     = |(rca_idle & slot_onehot(hold_q.rca_id));

   // Payload comes straight from the holding register so it is stable for the whole handshake.
   assign prc_rca_id    = hold_q.rca_id;
   assign prc_cfg_id    = hold_q.cfg_id;
   assign status_rca_id = hold_q.rca_id;
   assign status_error  = err_q;

   // Does the requested config already sit in the requested slot?
   always_comb begin
      loaded_match = 1'b0;
      for (int i = 0; i < NUM_RCAS; i++) begin
         if (req_rca_id == RCA_ID_W'(i) && cur_cfg_id[i*CFG_ID_W +: CFG_ID_W] == req_cfg_id)
            loaded_match = 1'b1;
      end
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and control decode.
   // NOTE: every output of this block gets a default first, otherwise untaken branches infer latches.
   always_comb begin
      state_nxt    = state;
      req_ready    = 1'b0;
      prc_valid    = 1'b0;
      status_valid = 1'b0;
      pop          = 1'b0;
      pop_err      = 1'b0;
      pop_stall    = 1'b0;
      err_load     = 1'b0;
      err_val      = 1'b0;
      cnt_clr      = 1'b0;
      tbl_we       = 1'b0;
      tbl_wdata    = INVALID_CFG;
      unique case (state)
         IDLE: begin
            // Held low while reset is asserted so all outputs read 0 during reset.
            req_ready = rst_n;
            if (req_valid) begin
               pop = 1'b1;
               if (!req_in_range) begin
                  pop_err   = 1'b1;
                  state_nxt = REPORT;
               end else if (loaded_match) begin
                  state_nxt = REPORT;
               end else if (req_cfg_id == INVALID_CFG) begin
                  pop_err   = 1'b1;
                  state_nxt = REPORT;
               end else begin
                  pop_stall = 1'b1;
                  state_nxt = WAIT_DRAIN;
               end
            end
         end
         WAIT_DRAIN: begin
            if (drain_ok) state_nxt = TRIGGER;
         end
         TRIGGER: begin
            prc_valid = 1'b1;
            if (prc_ready) begin
               cnt_clr   = 1'b1;
               tbl_we    = 1'b1;
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (prc_error) begin
               err_load  = 1'b1;
               err_val   = 1'b1;
               state_nxt = REPORT;
            end else if (prc_done) begin
               err_load  = 1'b1;
               tbl_we    = 1'b1;
               tbl_wdata = hold_q.cfg_id;
               state_nxt = REPORT;
            end else if (cnt_q == CNT_LAST) begin
               err_load  = 1'b1;
               err_val   = 1'b1;
               state_nxt = REPORT;
            end
         end
         REPORT: begin
            status_valid = 1'b1;
            state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request holding register, result flag, saturating timeout counter and stall flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q            <= '0;
         err_q             <= 1'b0;
         cnt_q             <= '0;
         rca_reconfiguring <= '0;
      end else begin
         if (pop) begin
            hold_q <= '{rca_id: req_rca_id, cfg_id: req_cfg_id};
            err_q  <= pop_err;
         end else if (err_load) begin
            err_q  <= err_val;
         end
         if (cnt_clr)                                   cnt_q <= '0;
         else if (state == WAIT_DONE && cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
         if (pop_stall)             rca_reconfiguring <= slot_onehot(req_rca_id);
         else if (state == REPORT)  rca_reconfiguring <= '0;
      end
   end

   rca_pr_controller_cfg_table u_cfg_table (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (tbl_we),
      .wr_idx  (hold_q.rca_id),
      .wr_data (tbl_wdata),
      .rd_all  (cur_cfg_id)
   );

endmodule

// File: tb/tb_rca_pr_controller.sv
// Self-checking bench for rca_pr_controller: per-cycle behavioural model plus directed literal checks.
module tb_rca_pr_controller;
   import rca_pr_controller_pkg::*;

   localparam int TB_TIMEOUT = 16;

   logic                         clk = 1'b0;
   logic                         rst_n;
   logic                         req_valid, req_ready;
   logic [RCA_ID_W-1:0]          req_rca_id;
   logic [CFG_ID_W-1:0]          req_cfg_id;
   logic [NUM_RCAS-1:0]          rca_idle;
   logic                         prc_valid, prc_ready;
   logic [RCA_ID_W-1:0]          prc_rca_id;
   logic [CFG_ID_W-1:0]          prc_cfg_id;
   logic                         prc_done, prc_error;
   logic [NUM_RCAS-1:0]          rca_reconfiguring;
   logic [NUM_RCAS*CFG_ID_W-1:0] cur_cfg_id;
   logic                         status_valid;
   logic [RCA_ID_W-1:0]          status_rca_id;
   logic                         status_error;

   rca_pr_controller #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_rca_id(req_rca_id), .req_cfg_id(req_cfg_id),
      .rca_idle(rca_idle),
      .prc_valid(prc_valid), .prc_ready(prc_ready), .prc_rca_id(prc_rca_id), .prc_cfg_id(prc_cfg_id),
      .prc_done(prc_done), .prc_error(prc_error),
      .rca_reconfiguring(rca_reconfiguring), .cur_cfg_id(cur_cfg_id),
      .status_valid(status_valid), .status_rca_id(status_rca_id), .status_error(status_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {OUT_SKIP, OUT_REJECT, OUT_RECONF} outcome_t;

   logic [CFG_ID_W-1:0] m_tbl [NUM_RCAS];
   bit                  m_busy, m_draining, m_trig, m_flight, m_status_now, m_err;
   int                  m_slot, m_elapsed;
   logic [CFG_ID_W-1:0] m_cfg;
   logic [NUM_RCAS-1:0] m_stall;

   // Observation log used by the directed literal checks.
   int   pop_cyc, trig_first_cyc, hs_cyc, status_cyc;
   int   status_cnt = 0, trig_cycles = 0, stall_cycles = 0;
   int   last_status_rca;
   bit   last_status_err;
   bit   prev_prc_valid = 1'b0;

   function automatic outcome_t classify(input int r, input logic [CFG_ID_W-1:0] c);
      if (r >= NUM_RCAS)   return OUT_REJECT;
      if (c == m_tbl[r])   return OUT_SKIP;
      if (c == INVALID_CFG) return OUT_REJECT;
      return OUT_RECONF;
   endfunction

   function automatic logic [NUM_RCAS*CFG_ID_W-1:0] model_cfg_flat();
      logic [NUM_RCAS*CFG_ID_W-1:0] v;
      for (int i = 0; i < NUM_RCAS; i++) v[i*CFG_ID_W +: CFG_ID_W] = m_tbl[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_RCAS; i++) m_tbl[i] = INVALID_CFG;
      m_busy = 0; m_draining = 0; m_trig = 0; m_flight = 0; m_status_now = 0; m_err = 0;
      m_slot = 0; m_elapsed = 0; m_cfg = '0; m_stall = '0;
      prev_prc_valid = 1'b0;
   endtask

   // Compare DUT outputs with the model every cycle, then advance the model using the inputs
   // the DUT will sample at the coming edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         check("status_valid", status_valid, m_status_now);
         if (m_status_now) begin
            check("status_rca_id", status_rca_id, m_slot);
            check("status_error", status_error, m_err);
         end
         check("prc_valid", prc_valid, m_trig);
         if (m_trig) begin
            check("prc_rca_id", prc_rca_id, m_slot);
            check("prc_cfg_id", prc_cfg_id, m_cfg);
         end
         check("req_ready", req_ready, !m_busy);
         check("rca_reconfiguring", rca_reconfiguring, m_stall);
         check("stall_onehot", ($countones(rca_reconfiguring) <= 1), 1);
         check("cur_cfg_id", cur_cfg_id, model_cfg_flat());

         if (req_valid && req_ready) pop_cyc = cyc;
         if (prc_valid && !prev_prc_valid) trig_first_cyc = cyc;
         if (prc_valid) trig_cycles++;
         if (prc_valid && prc_ready) hs_cyc = cyc;
         if (rca_reconfiguring != '0) stall_cycles++;
         if (status_valid) begin
            status_cyc = cyc; status_cnt++;
            last_status_rca = int'(status_rca_id); last_status_err = status_error;
         end
         prev_prc_valid = prc_valid;

         if (m_status_now) begin
            m_status_now = 0; m_busy = 0; m_stall = '0;
         end else if (!m_busy) begin
            if (req_valid) begin
               m_busy = 1; m_slot = int'(req_rca_id); m_cfg = req_cfg_id;
               case (classify(m_slot, m_cfg))
                  OUT_SKIP:   begin m_status_now = 1; m_err = 0; end
                  OUT_REJECT: begin m_status_now = 1; m_err = 1; end
                  default:    begin m_draining = 1; m_stall = '0; m_stall[m_slot] = 1'b1; end
               endcase
            end
         end else if (m_draining) begin
            if (rca_idle[m_slot]) begin m_draining = 0; m_trig = 1; end
         end else if (m_trig) begin
            if (prc_ready) begin
               m_trig = 0; m_flight = 1; m_elapsed = 0; m_tbl[m_slot] = INVALID_CFG;
            end
         end else if (m_flight) begin
            if (prc_error) begin
               m_flight = 0; m_status_now = 1; m_err = 1;
            end else if (prc_done) begin
               m_flight = 0; m_status_now = 1; m_err = 0; m_tbl[m_slot] = m_cfg;
            end else if (m_elapsed == TB_TIMEOUT - 1) begin
               m_flight = 0; m_status_now = 1; m_err = 1;
            end else begin
               m_elapsed++;
            end
         end
      end
   end

   // ---------------- directed stimulus helpers ----------------
   // All helpers are entered and left just after a rising edge.
   task automatic push(input logic [RCA_ID_W-1:0] r, input logic [CFG_ID_W-1:0] c);
      bit seen = 0;
      req_rca_id = r; req_cfg_id = c; req_valid = 1'b1;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = req_ready;
      end
      check("wait_pop", 32'(seen), 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_hs();
      bit seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = prc_valid && prc_ready;
      end
      check("wait_handshake", 32'(seen), 1);
   endtask

   task automatic wait_prc_valid();
      bit seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = prc_valid;
      end
      check("wait_prc_valid", 32'(seen), 1);
   endtask

   task automatic wait_status();
      bit seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = status_valid;
      end
      check("wait_status", 32'(seen), 1);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, req_ready, 0);
      check({tag, "_prc_valid"}, prc_valid, 0);
      check({tag, "_prc_rca_id"}, prc_rca_id, 0);
      check({tag, "_prc_cfg_id"}, prc_cfg_id, 0);
      check({tag, "_reconfiguring"}, rca_reconfiguring, 0);
      check({tag, "_cur_cfg_id"}, cur_cfg_id, 12'hFFF);
      check({tag, "_status_valid"}, status_valid, 0);
      check({tag, "_status_rca_id"}, status_rca_id, 0);
      check({tag, "_status_error"}, status_error, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   int t_trig, t_stall, t_stat, rise_cyc;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_rca_id = '0; req_cfg_id = '0;
      rca_idle = 3'b111; prc_ready = 1'b0; prc_done = 1'b0; prc_error = 1'b0;
      repeat (2) @(posedge clk); #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: (1,5) full reconfiguration, done 10 cycles after the trigger.
      prc_ready = 1'b1;
      t_trig = trig_cycles; t_stall = stall_cycles;
      push(2'd1, 4'd5);
      wait_hs();
      repeat (10) @(posedge clk); #1 prc_done = 1'b1;
      @(posedge clk); #1 prc_done = 1'b0;
      wait_status();
      check("t1_pop_to_status", status_cyc - pop_cyc, 13);
      check("t1_trigger_cycles", trig_cycles - t_trig, 1);
      check("t1_stall_cycles", stall_cycles - t_stall, 13);
      check("t1_status_rca", last_status_rca, 1);
      check("t1_status_err", last_status_err, 0);
      check("t1_cfg_table", cur_cfg_id, 12'hF5F);

      // 2: repeat (1,5): already loaded, skipped.
      t_trig = trig_cycles; t_stall = stall_cycles;
      push(2'd1, 4'd5);
      wait_status();
      check("t2_pop_to_status", status_cyc - pop_cyc, 1);
      check("t2_trigger_cycles", trig_cycles - t_trig, 0);
      check("t2_stall_cycles", stall_cycles - t_stall, 0);
      check("t2_status_err", last_status_err, 0);

      // 3: (0,3): slot busy for 7 cycles (stray done pulse ignored), PRC accepts 4 cycles late.
      prc_ready = 1'b0; rca_idle = 3'b110;
      t_trig = trig_cycles;
      push(2'd0, 4'd3);
      @(posedge clk); #1 prc_done = 1'b1;
      @(posedge clk); #1 prc_done = 1'b0;
      repeat (5) @(posedge clk); #1;
      rca_idle = 3'b111; rise_cyc = cyc;
      wait_prc_valid();
      repeat (4) @(posedge clk); #1 prc_ready = 1'b1;
      repeat (3) @(posedge clk); #1 prc_done = 1'b1;
      @(posedge clk); #1 prc_done = 1'b0;
      wait_status();
      check("t3_trigger_after_idle", trig_first_cyc - rise_cyc, 1);
      check("t3_trigger_cycles", trig_cycles - t_trig, 5);
      check("t3_status_rca", last_status_rca, 0);
      check("t3_status_err", last_status_err, 0);
      check("t3_cfg_table", cur_cfg_id, 12'hF53);

      // 4: (2,7) with done and error together: error wins.
      push(2'd2, 4'd7);
      wait_hs();
      repeat (3) @(posedge clk); #1 begin prc_done = 1'b1; prc_error = 1'b1; end
      @(posedge clk); #1 begin prc_done = 1'b0; prc_error = 1'b0; end
      wait_status();
      check("t4_status_err", last_status_err, 1);
      check("t4_cfg_slot2", cur_cfg_id[11:8], 4'hF);
      check("t4_cfg_table", cur_cfg_id, 12'hF53);

      // 5: (2,6) with no response: timeout. WAIT_DONE spans counter values 0..15,
      // so REPORT follows the 16th edge after the handshake edge.
      push(2'd2, 4'd6);
      wait_hs();
      wait_status();
      check("t5_hs_to_status", status_cyc - hs_cyc, TB_TIMEOUT + 1);
      check("t5_status_err", last_status_err, 1);
      check("t5_status_rca", last_status_rca, 2);
      check("t5_flag_cleared", rca_reconfiguring, 0);

      // 6: rca 3 is out of range: rejected without trigger.
      t_trig = trig_cycles;
      push(2'd3, 4'd2);
      wait_status();
      check("t6_pop_to_status", status_cyc - pop_cyc, 1);
      check("t6_status_rca", last_status_rca, 3);
      check("t6_status_err", last_status_err, 1);
      check("t6_trigger_cycles", trig_cycles - t_trig, 0);

      // 7: reset during WAIT_DONE of (0,9): abort, no status pulse.
      push(2'd0, 4'd9);
      wait_hs();
      repeat (3) @(posedge clk); #1;
      check("t7_flag_before_reset", rca_reconfiguring, 3'b001);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      t_stat = status_cnt;
      repeat (2) @(posedge clk); #1 rst_n = 1'b1;
      repeat (10) @(posedge clk); #1;
      check("t7_no_status", status_cnt - t_stat, 0);
      check("t7_req_ready", req_ready, 1);
      check("t7_cfg_table", cur_cfg_id, 12'hFFF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
